regfile_dump: RTL

- Read-side companion to the 16x16 register file. On a start pulse it walks a range of register addresses through one regfile read port and streams each word out on a valid/ready interface.
- Used for debug readout, end-of-test register dumps, and context save.
- Sits between a regfile read port (raddra or raddrb) and a debug or serial transmitter.

---
 rtl/regfile_dump_pkg.sv | 14 +
 rtl/regfile_dump.sv | 83 ++++++++
 2 files changed

// File: rtl/regfile_dump_pkg.sv
// Shared widths and FSM encoding for the register-file dump engine.
package regfile_dump_pkg;

  localparam int unsigned DataW = 16;
  localparam int unsigned AddrW = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRead = 2'd1,
    StSend = 2'd2,
    StDone = 2'd3
  } state_e;

endpackage

// File: rtl/regfile_dump.sv
// Walks a wrapping range of register addresses through one regfile read port and
// streams each captured word out on a valid/ready interface.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int unsigned DATA_W = DataW,
  parameter int unsigned ADDR_W = AddrW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  state_e            state_q;
  logic [ADDR_W-1:0] cur_q;
  logic [ADDR_W-1:0] end_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cur_q     <= '0;
      end_q     <= '0;
      raddr     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            cur_q   <= first_addr;
            end_q   <= last_addr;
            raddr   <= first_addr;
            busy    <= 1'b1;
            state_q <= StRead;
          end
        end
        StRead: begin
          out_data  <= rdata;
          out_addr  <= cur_q;
          out_last  <= (cur_q == end_q);
          out_valid <= 1'b1;
          state_q   <= StSend;
        end
        StSend: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              done    <= 1'b1;
              state_q <= StDone;
            end else begin
              // Termination is cur == end; the address simply wraps.
              cur_q   <= cur_q + ADDR_W'(1);
              raddr   <= cur_q + ADDR_W'(1);
              state_q <= StRead;
            end
          end
        end
        StDone: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
